// File: rtl/mul_arbiter.sv
// Two-requester arbiter sharing one MUL datapath; latches the winner's operands and holds the tagged product until acknowledged.
// Build option: define MUL_ARB_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.

module MUL #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0]   a,
   input  logic [DATAWIDTH-1:0]   b,
   output logic [2*DATAWIDTH-1:0] prod
);
   logic [2*DATAWIDTH-1:0] a_ext;
   logic [2*DATAWIDTH-1:0] b_ext;

   assign a_ext = {{DATAWIDTH{1'b0}}, a};
   assign b_ext = {{DATAWIDTH{1'b0}}, b};
   assign prod  = a_ext * b_ext;
endmodule

// state   | meaning
// IDLE    | arbitrate; combinational grant, latch winner operands and id
// COMPUTE | shared multiplier evaluates latched operands
// DONE    | product held with Valid until Ack
module mul_arbiter #(
   parameter int DATAWIDTH = 8
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Req0,
   input  logic [DATAWIDTH-1:0]   A0,
   input  logic [DATAWIDTH-1:0]   B0,
   output logic                   Gnt0,
   input  logic                   Req1,
   input  logic [DATAWIDTH-1:0]   A1,
   input  logic [DATAWIDTH-1:0]   B1,
   output logic                   Gnt1,
   output logic [2*DATAWIDTH-1:0] D,
   output logic                   Valid,
   output logic                   Id,
   input  logic                   Ack
);
   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

   state_t                 state;
   logic [DATAWIDTH-1:0]   op_a;
   logic [DATAWIDTH-1:0]   op_b;
   logic [2*DATAWIDTH-1:0] prod;
   logic                   pick0;
   logic                   pick1;
   logic                   in_idle;

`ifdef MUL_ARB_PRIO_EN
   assign pick0 = Req0;
`else
   logic last;
   // Requester 0 wins contention only when requester 1 took the previous grant
   assign pick0 = Req0 & (~Req1 | last);
`endif
   assign pick1 = Req1 & ~pick0;

   // Rst gates the grants so they read low while reset is asserted
   assign in_idle = Rst & (state == S_IDLE);
   assign Gnt0    = in_idle & pick0;
   assign Gnt1    = in_idle & pick1;

   MUL #(.DATAWIDTH(DATAWIDTH)) u_mul (
      .a    (op_a),
      .b    (op_b),
      .prod (prod)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= S_IDLE;
         op_a  <= '0;
         op_b  <= '0;
         D     <= '0;
         Valid <= 1'b0;
         Id    <= 1'b0;
`ifndef MUL_ARB_PRIO_EN
         last  <= 1'b1;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (pick0 || pick1) begin
                  op_a  <= pick1 ? A1 : A0;
                  op_b  <= pick1 ? B1 : B0;
                  Id    <= pick1;
`ifndef MUL_ARB_PRIO_EN
                  last  <= pick1;
`endif
                  state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               D     <= prod;
               Valid <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               if (Ack) begin
                  Valid <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter (DATAWIDTH=8); expectations follow MUL_ARB_PRIO_EN when defined.

module tb_mul_arbiter;
   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          Req0 = 1'b0, Req1 = 1'b0, Ack = 1'b0;
   logic [DW-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic          Gnt0, Gnt1, Valid, Id;
   logic [2*DW-1:0] D;

   int n_checks = 0;
   int n_fail   = 0;

   mul_arbiter #(.DATAWIDTH(DW)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req0(Req0), .A0(A0), .B0(B0), .Gnt0(Gnt0),
      .Req1(Req1), .A1(A1), .B1(B1), .Gnt1(Gnt1),
      .D(D), .Valid(Valid), .Id(Id), .Ack(Ack)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // advance from one falling edge to the next
   task automatic cyc();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_w;

      // reset values
      #3;
      chk("rst_d", D, 0);
      chk("rst_valid", Valid, 0);
      chk("rst_id", Id, 0);
      chk("rst_gnt0", Gnt0, 0);
      chk("rst_gnt1", Gnt1, 0);
      @(negedge Clk);
      Rst = 1'b1;

      // idle with no requests
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_gnt0", Gnt0, 0);
         chk("idle_gnt1", Gnt1, 0);
         chk("idle_valid", Valid, 0);
         chk("idle_d", D, 0);
      end

      // single op 12*11
      Req0 = 1; A0 = 8'd12; B0 = 8'd11; Ack = 1;
      #1;
      chk("single_gnt0", Gnt0, 1);
      chk("single_gnt1", Gnt1, 0);
      @(posedge Clk); #1; Req0 = 0;
      @(negedge Clk);
      chk("single_compute_valid", Valid, 0);
      chk("single_compute_gnt0", Gnt0, 0);
      cyc();
      chk("single_valid", Valid, 1);
      chk("single_d", D, 132);
      chk("single_id", Id, 0);
      cyc();
      chk("single_back_idle", Valid, 0);

      // max operands from requester 1
      Req1 = 1; A1 = 8'd255; B1 = 8'd255;
      #1;
      chk("max_gnt1", Gnt1, 1);
      chk("max_gnt0", Gnt0, 0);
      @(posedge Clk); #1; Req1 = 0;
      @(negedge Clk);
      cyc();
      chk("max_valid", Valid, 1);
      chk("max_d", D, 32'hFE01);
      chk("max_id", Id, 1);
      cyc();

      // contention: both requesters held
      Req0 = 1; A0 = 8'd3; B0 = 8'd5;
      Req1 = 1; A1 = 8'd7; B1 = 8'd9;
      for (int k = 0; k < 4; k++) begin
`ifdef MUL_ARB_PRIO_EN
         exp_w = 1'b0;
`else
         exp_w = k[0];
`endif
         #1;
         chk("cont_gnt0", Gnt0, !exp_w);
         chk("cont_gnt1", Gnt1, exp_w);
         cyc();
         chk("cont_compute_gnt", {Gnt0, Gnt1}, 0);
         cyc();
         chk("cont_valid", Valid, 1);
         chk("cont_id", Id, exp_w);
         chk("cont_d", D, exp_w ? 63 : 15);
         chk("cont_done_gnt", {Gnt0, Gnt1}, 0);
         cyc();
      end
      Req0 = 0; Req1 = 0;
      cyc();

      // backpressure with requester 1 waiting
      Ack = 0; Req0 = 1; A0 = 8'd10; B0 = 8'd20;
      #1;
      chk("bp_gnt0", Gnt0, 1);
      @(posedge Clk); #1;
      Req0 = 0; Req1 = 1; A1 = 8'd2; B1 = 8'd3;
      @(negedge Clk);
      chk("bp_compute_gnt1", Gnt1, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_valid", Valid, 1);
         chk("bp_d", D, 200);
         chk("bp_id", Id, 0);
         chk("bp_gnt1", Gnt1, 0);
      end
      Ack = 1;
      #1;
      chk("bp_ack_cycle_gnt1", Gnt1, 0);
      @(negedge Clk);
      chk("bp_valid_drop", Valid, 0);
      chk("bp_gnt1_after_ack", Gnt1, 1);
      @(posedge Clk); #1; Req1 = 0;
      @(negedge Clk);
      cyc();
      chk("bp_r1_d", D, 6);
      chk("bp_r1_id", Id, 1);
      cyc();

      // reset during COMPUTE of a requester 0 op
      Req0 = 1; A0 = 8'd6; B0 = 8'd7;
      #1;
      chk("rm_gnt0", Gnt0, 1);
      @(posedge Clk); #1; Req0 = 0;
      @(negedge Clk);
      Rst = 0;
      #1;
      chk("rm_valid", Valid, 0);
      chk("rm_d", D, 0);
      chk("rm_id", Id, 0);
      cyc();
      Rst = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rm_no_result", Valid, 0);
         chk("rm_d_zero", D, 0);
      end
      Req0 = 1; Req1 = 1;
      #1;
      chk("rm_cont_gnt0", Gnt0, 1);
      chk("rm_cont_gnt1", Gnt1, 0);
      @(posedge Clk); #1; Req0 = 0; Req1 = 0;
      @(negedge Clk);
      cyc();
      chk("rm_cont_d", D, 42);
      chk("rm_cont_id", Id, 0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
